// File: rtl/uart_tx_fifo_p_if.sv
// Host/transmitter-side bundle of the UART transmit FIFO: write port, read port and status.
interface uart_tx_fifo_p_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  logic                       flush;
  logic                       wr_en;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       rd_en;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic                       rd_valid;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic [$clog2(DEPTH):0]     level;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/uart_tx_fifo_p.sv
// UART transmit FIFO: circular buffer with occupancy flags and sticky errors.
// Define UART_TX_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module uart_tx_fifo_p #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input logic              clk,
  input logic              areset_n,
  uart_tx_fifo_p_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [LW-1:0]         r_level;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = bus.rd_en && !w_empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign w_push  = bus.wr_en && (!w_full || w_pop);

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_level >= LW'(AF_THRESH));
  assign bus.almost_empty = (r_level <= LW'(AE_THRESH));
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // NOTE: state registers use non-blocking assignments so every always_ff samples pre-edge values.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      if (bus.wr_en && !w_push) r_overflow  <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; stale words are unreachable once the pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush) r_mem[r_wptr] <= bus.wr_data;
  end

`ifdef UART_TX_FIFO_FWFT_EN
  assign bus.rd_data  = r_mem[r_rptr];
  assign bus.rd_valid = !w_empty;
`else
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (bus.flush) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) r_rd_data <= r_mem[r_rptr];
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
`endif
endmodule

// File: tb/tb_uart_tx_fifo_p.sv
// Directed bench for uart_tx_fifo_p (DEPTH=16, 8-bit); builds in both UART_TX_FIFO_FWFT_EN modes.
module tb_uart_tx_fifo_p;
  logic clk;
  logic areset_n;
  int   n_vec = 0;
  int   n_err = 0;

  uart_tx_fifo_p_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  uart_tx_fifo_p #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // One clock of stimulus; returns the word/valid the consumer sees for this pop.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re,
                       output logic [7:0] d, output logic v);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
`ifdef UART_TX_FIFO_FWFT_EN
    d = bus.rd_data;
    v = bus.rd_valid;
    @(posedge clk); #1;
`else
    @(posedge clk); #1;
    d = bus.rd_data;
    v = bus.rd_valid;
`endif
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset;
    areset_n  = 1'b0;
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    #23;
    n_vec++;
    if (bus.level !== 5'd0) begin
      n_err++; $display("FAIL reset_level: got %0d, want 0", bus.level);
    end
    n_vec++;
    if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100) begin
      n_err++; $display("FAIL reset_flags: got e/ae/f/af=%b, want 1100",
                        {bus.empty, bus.almost_empty, bus.full, bus.almost_full});
    end
    n_vec++;
    if ({bus.overflow, bus.underflow, bus.rd_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_err_valid: got ov/un/rv=%b, want 000",
                        {bus.overflow, bus.underflow, bus.rd_valid});
    end
`ifndef UART_TX_FIFO_FWFT_EN
    n_vec++;
    if (bus.rd_data !== 8'h00) begin
      n_err++; $display("FAIL reset_rd_data: got %h, want 00", bus.rd_data);
    end
`endif
    @(negedge clk) areset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain;
    logic [7:0] d;
    logic       v;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'h11 + 8'(i), 1'b0, d, v);
      n_vec++;
      if (bus.level !== 5'(i + 1)) begin
        n_err++; $display("FAIL fill_level[%0d]: got %0d, want %0d", i, bus.level, i + 1);
      end
      n_vec++;
      if (bus.almost_full !== (i + 1 >= 14)) begin
        n_err++; $display("FAIL fill_almost_full[%0d]: got %b, want %b", i, bus.almost_full, (i + 1 >= 14));
      end
    end
    n_vec++;
    if (bus.full !== 1'b1) begin
      n_err++; $display("FAIL fill_full: got %b, want 1", bus.full);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, d, v);
      n_vec++;
      if (d !== 8'h11 + 8'(i) || v !== 1'b1) begin
        n_err++; $display("FAIL drain_data[%0d]: got %h/v%b, want %h/v1", i, d, v, 8'h11 + 8'(i));
      end
    end
    n_vec++;
    if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin
      n_err++; $display("FAIL drain_empty: got e/ae=%b%b, want 11", bus.empty, bus.almost_empty);
    end
    cycle(1'b0, 8'h00, 1'b0, d, v);
    n_vec++;
    if (bus.rd_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_valid_idle: got %b, want 0", bus.rd_valid);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    logic       v;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h11 + 8'(i), 1'b0, d, v);
    cycle(1'b1, 8'hAA, 1'b0, d, v);
    n_vec++;
    if (bus.overflow !== 1'b1 || bus.level !== 5'd16) begin
      n_err++; $display("FAIL ovf_set: got ov=%b lvl=%0d, want ov=1 lvl=16", bus.overflow, bus.level);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, d, v);
      n_vec++;
      if (d !== 8'h11 + 8'(i) || v !== 1'b1) begin
        n_err++; $display("FAIL ovf_drain[%0d]: got %h/v%b, want %h/v1", i, d, v, 8'h11 + 8'(i));
      end
    end
    n_vec++;
    if (bus.overflow !== 1'b1 || bus.empty !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got ov=%b e=%b, want 1 1", bus.overflow, bus.empty);
    end
    // Flush beats simultaneous write and read: nothing stored, no underflow.
    bus.flush = 1'b1;
    cycle(1'b1, 8'h77, 1'b1, d, v);
    bus.flush = 1'b0;
    n_vec++;
    if (bus.level !== 5'd0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.empty !== 1'b1) begin
      n_err++; $display("FAIL flush: got lvl=%0d ov=%b un=%b e=%b, want 0 0 0 1",
                        bus.level, bus.overflow, bus.underflow, bus.empty);
    end
    n_vec++;
    if (bus.rd_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_valid: got %b, want 0", bus.rd_valid);
    end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] d;
    logic       v;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, d, v);
    cycle(1'b1, 8'h55, 1'b1, d, v);
    n_vec++;
    if (d !== 8'h30 || v !== 1'b1 || bus.level !== 5'd16 || bus.overflow !== 1'b0) begin
      n_err++; $display("FAIL full_rw: got %h/v%b lvl=%0d ov=%b, want 30/v1 lvl=16 ov=0",
                        d, v, bus.level, bus.overflow);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i == 15) ? 8'h55 : 8'h31 + 8'(i);
      cycle(1'b0, 8'h00, 1'b1, d, v);
      n_vec++;
      if (d !== exp || v !== 1'b1) begin
        n_err++; $display("FAIL full_rw_drain[%0d]: got %h/v%b, want %h/v1", i, d, v, exp);
      end
    end
    n_vec++;
    if (bus.empty !== 1'b1) begin
      n_err++; $display("FAIL full_rw_empty: got %b, want 1", bus.empty);
    end
  endtask

  task automatic test_underflow;
    logic [7:0] d;
    logic       v;
    cycle(1'b1, 8'h3C, 1'b1, d, v);
    n_vec++;
    if (bus.underflow !== 1'b1 || v !== 1'b0 || bus.level !== 5'd1) begin
      n_err++; $display("FAIL unf_set: got un=%b v=%b lvl=%0d, want 1 0 1", bus.underflow, v, bus.level);
    end
    cycle(1'b0, 8'h00, 1'b1, d, v);
    n_vec++;
    if (d !== 8'h3C || v !== 1'b1) begin
      n_err++; $display("FAIL unf_pop: got %h/v%b, want 3c/v1", d, v);
    end
    n_vec++;
    if (bus.underflow !== 1'b1) begin
      n_err++; $display("FAIL unf_sticky: got %b, want 1", bus.underflow);
    end
    bus.flush = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, d, v);
    bus.flush = 1'b0;
    n_vec++;
    if (bus.underflow !== 1'b0) begin
      n_err++; $display("FAIL unf_flush: got %b, want 0", bus.underflow);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    logic       v;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, d, v);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'h83 + 8'(i), 1'b1, d, v);
      n_vec++;
      if (d !== 8'h80 + 8'(i) || v !== 1'b1 || bus.level !== 5'd3) begin
        n_err++; $display("FAIL b2b[%0d]: got %h/v%b lvl=%0d, want %h/v1 lvl=3",
                          i, d, v, bus.level, 8'h80 + 8'(i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, d, v);
      n_vec++;
      if (d !== 8'hA8 + 8'(i) || v !== 1'b1) begin
        n_err++; $display("FAIL b2b_tail[%0d]: got %h/v%b, want %h/v1", i, d, v, 8'hA8 + 8'(i));
      end
    end
    n_vec++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got e/ov/un=%b%b%b, want 100", bus.empty, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] d;
    logic       v;
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, d, v);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h47;
    bus.rd_en   = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus.level !== 5'd7 || bus.rd_valid !== 1'b1) begin
      n_err++; $display("FAIL ares_pre: got lvl=%0d rv=%b, want 7 1", bus.level, bus.rd_valid);
    end
    #2 areset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin
      n_err++; $display("FAIL ares_async: got lvl=%0d e=%b rv=%b, want 0 1 0",
                        bus.level, bus.empty, bus.rd_valid);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge clk) areset_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 8'h01, 1'b0, d, v);
    cycle(1'b0, 8'h00, 1'b1, d, v);
    n_vec++;
    if (d !== 8'h01 || v !== 1'b1 || bus.empty !== 1'b1) begin
      n_err++; $display("FAIL ares_after: got %h/v%b e=%b, want 01/v1 e=1", d, v, bus.empty);
    end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_overflow;
    test_full_push_pop;
    test_underflow;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_p.md
# uart_tx_fifo_p

Parametrised transmit FIFO for the UART datapath, sitting between the host write interface and the UART transmitter's shift register. It buffers DATA_WIDTH-bit words in a DEPTH-entry circular buffer on a single system clock, and reports occupancy, almost-full/almost-empty thresholds and sticky overflow/underflow errors. It also supports a synchronous flush, and has a compile-time choice between registered-read and first-word-fall-through output.

## Interface
- DATA_WIDTH, 8, word width in bits (1..32)
- DEPTH, 16, number of entries; power of two, 4..256
- AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)
- clk  in  1  system clock; all state changes on rising edge
- areset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read/pop request (from transmitter)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data holds a newly popped word (registered mode only; see Configuration)
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH
- almost_empty  out  1  level <= AE_THRESH
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage: mem[DEPTH], write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0 with no special case. level is a separate registered counter.
- Accepted pop: pop = rd_en && !empty.
- Accepted push: push = wr_en && (!full || pop). Writing when full is accepted only when a pop occurs in the same cycle.
- Rejected requests:
  - wr_en && !push sets overflow; data is discarded and wptr and level are unchanged.
  - rd_en && empty sets underflow. This applies even if wr_en is high in the same cycle: there is no bypass, and the written word is stored.
- level update: push only → level+1; pop only → level−1; both or neither → unchanged.
- Flags (full, empty, almost_full, almost_empty) are decoded combinationally from registered level.
- flush: wptr, rptr and level go to 0; overflow and underflow clear; mem is untouched.
  - flush has priority over wr_en/rd_en in the same cycle; neither request takes effect.
  - rd_data holds its value; rd_valid goes to 0 next cycle.
- Reset (areset_n low, any time including mid-transfer):
  - immediately: pointers, level, overflow, underflow, rd_valid = 0; rd_data = 0.
  - resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0.
  - mem contents are not reset.

## Timing
- Write-to-read latency: a word pushed at edge N is visible (empty deasserts) after edge N; the earliest pop is at edge N+1.
- Registered mode: on pop at edge N, rd_data = mem[rptr] and rd_valid = 1 after edge N. rd_valid is a 1-cycle pulse per pop; rd_data holds until the next pop.
- FWFT mode: rd_data = mem[rptr] combinationally while !empty; pop at edge N advances to the next word.
- Back-to-back push and pop at one word per cycle is sustained indefinitely, including when level == DEPTH or level == 0 with push only.
- Error flags assert the edge after the offending request and hold until flush or reset.

## Configuration
- Macro: UART_TX_FIFO_FWFT_EN.
- Defined: first-word-fall-through as described above.
  - rd_valid is tied to !empty.
  - Read latency is 0 cycles.
- Undefined (default): registered read.
  - rd_data and rd_valid are updated one edge after the pop.
  - Read latency is 1 cycle.
- All other behaviour is identical in both modes.

## Test plan
- Reset, then write 0x11..0x20 (16 words, DEPTH=16) → full=1, level=16, almost_full asserts at level 14. Pop 16 → data out 0x11..0x20 in order, empty=1.
- When full, wr_en with 0xAA and no rd_en → overflow=1, level stays 16, 0xAA never appears on output. Then flush → level=0, overflow=0.
- When full, assert wr_en(0x55) and rd_en in the same cycle → level stays 16; 0x55 is popped last after 16 further reads.
- When empty, assert rd_en with wr_en(0x3C) in the same cycle → underflow=1 and no rd_valid (registered mode). Next cycle, pop → 0x3C.
- Continuous push+pop for 40 cycles (pointer wrap 2.5×) at level 3 → output sequence equals input, level constant at 3.
- Assert areset_n low while level=7 mid-stream → level=0, empty=1, rd_valid=0 immediately (asynchronously). After release, a write of 0x01 then read of 0x01 succeeds.
- Run all scenarios with UART_TX_FIFO_FWFT_EN both defined and undefined.
